divmod_select_seq: RTL and testbench
====================================

// Module: divmod_select_seq
// PURPOSE
//  Multi-cycle, handshaked successor to the combinational divide/modulo/select datapath.
//  - Computes e=a/b, f=c/d and g=a%b with two radix-2 restoring dividers running in lock-step.
//  - Returns z = (g==zero) ? f : e.
//  - Sits between valid/ready-handshaked stages of the HLS datapath.
//  - Replaces the single-cycle DIV/MOD/COMP/MUX2x1/REG chain where its timing cannot close.
// PARAMETERS
//  DATAWIDTH  64  width of a, b, c, d, zero, z, q_e, q_f, r_g (must be >=2)
// PORTS
//  Clk        in   1          clock; all state updates on rising edge
//  Rst        in   1          asynchronous active-low reset; 0 clears all state immediately
//  in_valid   in   1          operand set a,b,c,d,zero presented
//  in_ready   out  1          block can accept operands (high only in IDLE)
//  a,b,c,d    in   DATAWIDTH  unsigned operands: dividends a,c; divisors b,d
//  zero       in   DATAWIDTH  compare reference for remainder a%b
//  out_valid  out  1          z and debug outputs valid
//  out_ready  in   1          downstream accepts result
//  z          out  DATAWIDTH  selected quotient, registered
//  q_e,q_f    out  DATAWIDTH  a/b and c/d, registered
//  r_g        out  DATAWIDTH  a%b, registered
//  sel        out  1          registered (r_g==zero)
// BEHAVIOUR
//  Reset (Rst=0, async):
//   - state=IDLE, in_ready=1, out_valid=0.
//   - z, q_e, q_f, r_g, sel, iteration counter and operand registers all 0.
//   - Reset mid-CALC or mid-DONE aborts the operation; no result is ever emitted for it.
//  State machine:
//   - IDLE: in_ready=1. On in_valid=1, latch a,b,c,d,zero; clear partial remainders; cnt=DATAWIDTH-1; go CALC.
//   - CALC: in_ready=0, out_valid=0. Each cycle both dividers perform one restoring step, MSB first.
//     Step: R={R[W-2:0],dividend[cnt]}; if R>=divisor then R=R-divisor, quotient bit[cnt]=1.
//     Partial remainder is DATAWIDTH+1 bits internally so the shift cannot overflow.
//     When cnt==0, after that step: load q_e, q_f, r_g; sel=(r_g==zero); z=sel?q_f:q_e; go DONE.
//   - DONE: out_valid=1; outputs held stable. On out_ready=1, go IDLE (out_valid low next cycle).
//  Latency:
//   - Handshake accepted at edge T gives out_valid=1 at edge T+DATAWIDTH (DATAWIDTH CALC cycles).
//   - Throughput: one result per DATAWIDTH+2 cycles with out_ready held high.
//  Handshake rules:
//   - Operands are sampled only on the accepting edge; later changes to a..zero are ignored.
//   - in_ready depends on state only (no combinational path from out_ready).
//   - in_valid is ignored while not in IDLE; nothing queues.
//   - out_valid, once high, stays high with z stable until out_ready=1.
//   - out_valid and in_ready are never high together.
//  Arithmetic:
//   - All unsigned; no truncation; the zero compare is a full DATAWIDTH equality.
//  Divide by zero: no trap, no special state, same cycle count.
//   - b==0 gives q_e={DATAWIDTH{1}} and r_g=a; d==0 gives q_f={DATAWIDTH{1}}.
//   - This falls out of the restoring algorithm.
//  Simultaneous events:
//   - in_valid while in DONE: no accept.
//   - out_ready while in CALC: no effect.
//   - Rst asserted anywhere overrides all.
// TESTING (DATAWIDTH=8 unless noted)
//  1 a=20,b=5,c=100,d=3,zero=0 -> r_g=0, sel=1, z=33; out_valid exactly 8 edges after accept.
//  2 a=23,b=5,c=100,d=3,zero=0 -> q_e=4, r_g=3, sel=0, z=4; then zero=3 in a new transaction -> z=33.
//  3 a=17,b=0,c=9,d=0,zero=17 -> q_e=8'hFF, r_g=17, sel=1, z=8'hFF; same 8-cycle latency.
//  4 out_ready=0 for 5 cycles in DONE -> out_valid and z stable, in_ready=0, extra in_valid pulses ignored.
//     Then out_ready=1 -> IDLE; next operand set accepted on the following edge.
//  5 Rst=0 at CALC iteration 4, mid-clock (async) -> outputs cleared immediately, in_ready=1 after release.
//     No out_valid ever appears for the aborted operation.
//  6 DATAWIDTH=64: a=2^64-1,b=1,c=2^63,d=2^32,zero=0 -> r_g=0, z=2^31.
//     Also run 1000 random operand sets against a reference /,% model, with random in_valid/out_ready.

Source files
------------

// File: rtl/divmod_select_seq.sv
// Multi-cycle divide/modulo/select: two lock-step radix-2 restoring dividers compute
// a/b, c/d and a%b, then z picks c/d when a%b equals the reference, else a/b.
module divmod_select_seq #(
    parameter int DATAWIDTH = 64
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATAWIDTH-1:0] a,
    input  logic [DATAWIDTH-1:0] b,
    input  logic [DATAWIDTH-1:0] c,
    input  logic [DATAWIDTH-1:0] d,
    input  logic [DATAWIDTH-1:0] zero,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATAWIDTH-1:0] z,
    output logic [DATAWIDTH-1:0] q_e,
    output logic [DATAWIDTH-1:0] q_f,
    output logic [DATAWIDTH-1:0] r_g,
    output logic                 sel
);

    localparam int W  = DATAWIDTH;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t         r_state, w_next;
    logic [W-1:0]   r_a, r_b, r_c, r_d, r_zero;
    logic [W-1:0]   r_rem_e, r_rem_f;
    logic [W-1:0]   r_qe, r_qf;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_z, r_q_e, r_q_f, r_r_g;
    logic           r_sel;

    logic [W:0]     w_sh_e, w_sh_f;
    logic           w_ge_e, w_ge_f;
    logic [W-1:0]   w_rem_e_n, w_rem_f_n;
    logic [W-1:0]   w_qe_n, w_qf_n;
    logic           w_last, w_sel_n, w_accept;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_last   = (r_cnt == '0);

    // One restoring step per divider; the extra shifted bit keeps the compare exact.
    always_comb begin
        w_sh_e    = {r_rem_e, r_a[r_cnt]};
        w_sh_f    = {r_rem_f, r_c[r_cnt]};
        w_ge_e    = (w_sh_e >= {1'b0, r_b});
        w_ge_f    = (w_sh_f >= {1'b0, r_d});
        w_rem_e_n = w_ge_e ? W'(w_sh_e - {1'b0, r_b}) : w_sh_e[W-1:0];
        w_rem_f_n = w_ge_f ? W'(w_sh_f - {1'b0, r_d}) : w_sh_f[W-1:0];
        w_qe_n         = r_qe;
        w_qe_n[r_cnt]  = w_ge_e;
        w_qf_n         = r_qf;
        w_qf_n[r_cnt]  = w_ge_f;
        w_sel_n   = (w_rem_e_n == r_zero);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_CALC;
            S_CALC:  if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_d     <= '0;
            r_zero  <= '0;
            r_rem_e <= '0;
            r_rem_f <= '0;
            r_qe    <= '0;
            r_qf    <= '0;
            r_cnt   <= '0;
            r_z     <= '0;
            r_q_e   <= '0;
            r_q_f   <= '0;
            r_r_g   <= '0;
            r_sel   <= 1'b0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_c     <= c;
            r_d     <= d;
            r_zero  <= zero;
            r_rem_e <= '0;
            r_rem_f <= '0;
            r_qe    <= '0;
            r_qf    <= '0;
            r_cnt   <= CW'(W - 1);
        end else if (r_state == S_CALC) begin
            r_rem_e <= w_rem_e_n;
            r_rem_f <= w_rem_f_n;
            r_qe    <= w_qe_n;
            r_qf    <= w_qf_n;
            r_cnt   <= r_cnt - 1'b1;
            if (w_last) begin
                r_q_e <= w_qe_n;
                r_q_f <= w_qf_n;
                r_r_g <= w_rem_e_n;
                r_sel <= w_sel_n;
                r_z   <= w_sel_n ? w_qf_n : w_qe_n;
            end
        end
    end

    assign z   = r_z;
    assign q_e = r_q_e;
    assign q_f = r_q_f;
    assign r_g = r_r_g;
    assign sel = r_sel;

endmodule

// File: tb/tb_divmod_select_seq.sv
// Bench for divmod_select_seq: 8-bit and 64-bit instances, scoreboard of expected results.
module tb_divmod_select_seq;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        use64;
    logic        in_valid, out_ready;
    logic [63:0] a, b, c, d, zero;

    always #5 Clk = ~Clk;

    logic        iv8, or8, ir8, ov8, sel8;
    logic [7:0]  z8, qe8, qf8, rg8;
    logic        iv64, or64, ir64, ov64, sel64;
    logic [63:0] z64, qe64, qf64, rg64;

    assign iv8  = in_valid  & ~use64;
    assign or8  = out_ready & ~use64;
    assign iv64 = in_valid  &  use64;
    assign or64 = out_ready &  use64;

    divmod_select_seq #(.DATAWIDTH(8)) u_dut8 (
        .Clk(Clk), .Rst(Rst), .in_valid(iv8), .in_ready(ir8),
        .a(a[7:0]), .b(b[7:0]), .c(c[7:0]), .d(d[7:0]), .zero(zero[7:0]),
        .out_valid(ov8), .out_ready(or8),
        .z(z8), .q_e(qe8), .q_f(qf8), .r_g(rg8), .sel(sel8)
    );

    divmod_select_seq #(.DATAWIDTH(64)) u_dut64 (
        .Clk(Clk), .Rst(Rst), .in_valid(iv64), .in_ready(ir64),
        .a(a), .b(b), .c(c), .d(d), .zero(zero),
        .out_valid(ov64), .out_ready(or64),
        .z(z64), .q_e(qe64), .q_f(qf64), .r_g(rg64), .sel(sel64)
    );

    logic        o_rdy, o_vld, o_sel;
    logic [63:0] o_z, o_qe, o_qf, o_rg;
    assign o_rdy = use64 ? ir64  : ir8;
    assign o_vld = use64 ? ov64  : ov8;
    assign o_sel = use64 ? sel64 : sel8;
    assign o_z   = use64 ? z64   : {56'b0, z8};
    assign o_qe  = use64 ? qe64  : {56'b0, qe8};
    assign o_qf  = use64 ? qf64  : {56'b0, qf8};
    assign o_rg  = use64 ? rg64  : {56'b0, rg8};

    typedef struct {
        logic [63:0] z, qe, qf, rg;
        logic        sel;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic exp_t model(input logic [63:0] ia, ib, ic, id, iz, input int w);
        exp_t        e;
        logic [63:0] m, aa, bb, cc, dd, zz;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << w) - 64'h1);
        aa = ia & m; bb = ib & m; cc = ic & m; dd = id & m; zz = iz & m;
        e.qe  = (bb == 0) ? m  : aa / bb;
        e.rg  = (bb == 0) ? aa : aa % bb;
        e.qf  = (dd == 0) ? m  : cc / dd;
        e.sel = (e.rg == zz);
        e.z   = e.sel ? e.qf : e.qe;
        return e;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Full transaction: accept, latency, result, optional DONE stall, release.
    task automatic send(input logic [63:0] ia, ib, ic, id, iz, input int stall, input bit junk);
        int   w;
        int   cyc;
        exp_t e;
        w = use64 ? 64 : 8;
        a = ia; b = ib; c = ic; d = id; zero = iz;
        in_valid = 1'b1;
        check("accept_ready", {63'b0, o_rdy}, 64'd1);
        tick();
        sb.push_back(model(ia, ib, ic, id, iz, w));
        in_valid = 1'b0;
        a = ~ia; b = ~ib; c = ~ic; d = ~id; zero = ~iz;
        check("busy_ready", {63'b0, o_rdy}, 64'd0);
        cyc = 0;
        while (!o_vld && cyc < w + 4) begin
            if (junk) in_valid = 1'($urandom_range(0, 1));
            out_ready = junk ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        check("latency", 64'(cyc), 64'(w));
        e = sb.pop_front();
        check("z",   o_z,  e.z);
        check("q_e", o_qe, e.qe);
        check("q_f", o_qf, e.qf);
        check("r_g", o_rg, e.rg);
        check("sel", {63'b0, o_sel}, {63'b0, e.sel});
        check("done_ready", {63'b0, o_rdy}, 64'd0);
        for (int s = 0; s < stall; s++) begin
            if (junk) in_valid = 1'($urandom_range(0, 1));
            tick();
            check("hold_valid", {63'b0, o_vld}, 64'd1);
            check("hold_z", o_z, e.z);
            check("hold_ready", {63'b0, o_rdy}, 64'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("release_valid", {63'b0, o_vld}, 64'd0);
        check("release_ready", {63'b0, o_rdy}, 64'd1);
    endtask

    initial begin
        logic [63:0] ra, rb, rc, rd, rz, rg;
        exp_t        tmp;
        bit          seen;
        Rst = 1'b0; use64 = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0; zero = '0;
        repeat (3) @(posedge Clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            use64 = (k == 1);
            #1;
            check("rst_ready", {63'b0, o_rdy}, 64'd1);
            check("rst_valid", {63'b0, o_vld}, 64'd0);
            check("rst_z", o_z, 64'd0);
            check("rst_rg", o_rg, 64'd0);
        end
        use64 = 1'b0;
        @(negedge Clk);
        Rst = 1'b1;
        tick();

        send(64'd20, 64'd5, 64'd100, 64'd3, 64'd0, 0, 0);
        send(64'd23, 64'd5, 64'd100, 64'd3, 64'd0, 0, 0);
        send(64'd23, 64'd5, 64'd100, 64'd3, 64'd3, 1, 0);
        send(64'd17, 64'd0, 64'd9,   64'd0, 64'd17, 5, 1);
        send(64'd200, 64'd7, 64'd255, 64'd255, 64'd4, 0, 0);

        // Abort mid-CALC with an asynchronous reset between clock edges.
        a = 64'd20; b = 64'd5; c = 64'd100; d = 64'd3; zero = 64'd0;
        in_valid = 1'b1;
        tick();
        sb.push_back(model(64'd20, 64'd5, 64'd100, 64'd3, 64'd0, 8));
        in_valid = 1'b0;
        repeat (4) tick();
        #2 Rst = 1'b0;
        #1;
        check("abort_valid", {63'b0, o_vld}, 64'd0);
        check("abort_ready", {63'b0, o_rdy}, 64'd1);
        check("abort_z", o_z, 64'd0);
        check("abort_qf", o_qf, 64'd0);
        check("abort_sel", {63'b0, o_sel}, 64'd0);
        tmp = sb.pop_back();
        @(negedge Clk);
        Rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_vld) seen = 1'b1;
        end
        check("abort_no_output", {63'b0, seen}, 64'd0);
        check("abort_ready_after", {63'b0, o_rdy}, 64'd1);
        check("abort_sb_empty", 64'(sb.size()), 64'd0);

        for (int i = 0; i < 1000; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            ra = 64'($urandom_range(0, 255));
            rb = ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            rc = 64'($urandom_range(0, 255));
            rd = ($urandom_range(0, 9) == 0) ? 64'd0 : 64'($urandom_range(0, 255));
            rg = (rb == 0) ? ra : ra % rb;
            rz = $urandom_range(0, 1) ? rg : 64'($urandom_range(0, 255));
            send(ra, rb, rc, rd, rz, $urandom_range(0, 3), 1);
        end

        use64 = 1'b1;
        tick();
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,
             64'h0000_0001_0000_0000, 64'd0, 2, 0);
        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom} >> $urandom_range(0, 63);
            rc = {$urandom, $urandom};
            rd = ($urandom_range(0, 7) == 0) ? 64'd0 : ({$urandom, $urandom} >> $urandom_range(0, 63));
            rg = (rb == 0) ? ra : ra % rb;
            rz = $urandom_range(0, 1) ? rg : {$urandom, $urandom};
            send(ra, rb, rc, rd, rz, $urandom_range(0, 2), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
